// File: rtl/control_unit.sv
// rtl/control_unit.sv - RV32I main decoder with registered control strobes
module control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic [6:0] opcode,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       ALUSrc,
   output logic       MemToReg,
   output logic       Branch,
   output logic       Jump,
   output logic [1:0] ALUOp,
   output logic       illegal
);

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic       reg_write_d;
   logic       mem_read_d;
   logic       mem_write_d;
   logic       alu_src_d;
   logic       mem_to_reg_d;
   logic       branch_d;
   logic       jump_d;
   logic [1:0] alu_op_d;
   logic       illegal_d;

   // Combinational opcode decode; anything outside the table (including X/Z) falls to the illegal default.
   always_comb begin
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      mem_to_reg_d = 1'b0;
      branch_d     = 1'b0;
      jump_d       = 1'b0;
      alu_op_d     = 2'b00;
      illegal_d    = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            reg_write_d = 1'b1;
            alu_op_d    = 2'b10;
         end
         OP_IALU: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
            alu_op_d    = 2'b11;
         end
         OP_LOAD: begin
            reg_write_d  = 1'b1;
            mem_read_d   = 1'b1;
            alu_src_d    = 1'b1;
            mem_to_reg_d = 1'b1;
         end
         OP_STORE: begin
            mem_write_d = 1'b1;
            alu_src_d   = 1'b1;
         end
         OP_BRANCH: begin
            branch_d = 1'b1;
            alu_op_d = 2'b01;
         end
         OP_JAL: begin
            reg_write_d = 1'b1;
            jump_d      = 1'b1;
         end
         OP_JALR: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
            jump_d      = 1'b1;
         end
         // LUI and AUIPC share strobes; operand A selection is handled in the datapath.
         OP_LUI, OP_AUIPC: begin
            reg_write_d = 1'b1;
            alu_src_d   = 1'b1;
         end
         default: begin
            illegal_d = 1'b1;
         end
      endcase
   end

   // Output flops: reset beats flush, flush inserts a NOP bubble, otherwise capture the decode.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         RegWrite <= 1'b0;
         MemRead  <= 1'b0;
         MemWrite <= 1'b0;
         ALUSrc   <= 1'b0;
         MemToReg <= 1'b0;
         Branch   <= 1'b0;
         Jump     <= 1'b0;
         ALUOp    <= 2'b00;
         illegal  <= 1'b0;
      end else begin
         RegWrite <= reg_write_d;
         MemRead  <= mem_read_d;
         MemWrite <= mem_write_d;
         ALUSrc   <= alu_src_d;
         MemToReg <= mem_to_reg_d;
         Branch   <= branch_d;
         Jump     <= jump_d;
         ALUOp    <= alu_op_d;
         illegal  <= illegal_d;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [6:0] opcode = 7'b0110011;
   logic       RegWrite, MemRead, MemWrite, ALUSrc, MemToReg, Branch, Jump, illegal;
   logic [1:0] ALUOp;

   control_unit dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .opcode   (opcode),
      .RegWrite (RegWrite),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .ALUSrc   (ALUSrc),
      .MemToReg (MemToReg),
      .Branch   (Branch),
      .Jump     (Jump),
      .ALUOp    (ALUOp),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   // expected word: {RW, MR, MW, AS, MTR, B, J, ALUOp[1:0], illegal}
   typedef struct {
      logic [9:0] exp;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   stim_done = 1'b0;

   localparam logic [9:0] E_NOP    = 10'b0000000_00_0;
   localparam logic [9:0] E_RTYPE  = 10'b1000000_10_0;
   localparam logic [9:0] E_IALU   = 10'b1001000_11_0;
   localparam logic [9:0] E_LOAD   = 10'b1101100_00_0;
   localparam logic [9:0] E_STORE  = 10'b0011000_00_0;
   localparam logic [9:0] E_BRANCH = 10'b0000010_01_0;
   localparam logic [9:0] E_JAL    = 10'b1000001_00_0;
   localparam logic [9:0] E_JALR   = 10'b1001001_00_0;
   localparam logic [9:0] E_LUI    = 10'b1001000_00_0;
   localparam logic [9:0] E_ILL    = 10'b0000000_00_1;

   // drive inputs at negedge, push the expectation once the capturing edge has passed
   task automatic step(input logic r, input logic f, input logic [6:0] op,
                       input logic [9:0] e, input string nm);
      exp_t item;
      @(negedge clk);
      rst    = r;
      flush  = f;
      opcode = op;
      @(posedge clk);
      item.exp  = e;
      item.name = nm;
      exp_q.push_back(item);
   endtask

   // monitor: outputs are stable at the negedge following each capturing edge
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t       it;
         logic [9:0] act;
         it  = exp_q.pop_front();
         act = {RegWrite, MemRead, MemWrite, ALUSrc, MemToReg, Branch, Jump, ALUOp, illegal};
         checks++;
         if (act !== it.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
         end
         checks++;
         if ((MemRead && MemWrite) || (MemToReg && !MemRead) || (Branch && Jump) ||
             (illegal && (RegWrite || MemWrite))) begin
            failures++;
            $display("FAIL invariant_%s: got %b expected consistent strobes", it.name, act);
         end
      end
   end

   initial begin
      step(1'b1, 1'b0, 7'b0110011, E_NOP,    "reset_1");
      step(1'b1, 1'b0, 7'b0110011, E_NOP,    "reset_2");
      step(1'b0, 1'b0, 7'b0110011, E_RTYPE,  "rtype_after_reset");
      step(1'b0, 1'b0, 7'b0010011, E_IALU,   "ialu");
      step(1'b0, 1'b0, 7'b0000011, E_LOAD,   "load");
      step(1'b0, 1'b0, 7'b0100011, E_STORE,  "store");
      step(1'b0, 1'b0, 7'b1100011, E_BRANCH, "branch");
      step(1'b0, 1'b0, 7'b1101111, E_JAL,    "jal");
      step(1'b0, 1'b0, 7'b1100111, E_JALR,   "jalr");
      step(1'b0, 1'b0, 7'b0110111, E_LUI,    "lui");
      step(1'b0, 1'b0, 7'b0010111, E_LUI,    "auipc");
      step(1'b0, 1'b0, 7'b1110011, E_ILL,    "system_illegal");
      step(1'b0, 1'b0, 7'b0000000, E_ILL,    "zero_illegal");
      step(1'b0, 1'b0, 7'b0110001, E_ILL,    "low_bits_illegal");
      step(1'b0, 1'b1, 7'b1110011, E_NOP,    "flush_clears_illegal");
      step(1'b0, 1'b1, 7'b0000011, E_NOP,    "flush_load");
      step(1'b0, 1'b0, 7'b0000011, E_LOAD,   "load_after_flush");
      step(1'b0, 1'b0, 7'b0000011, E_LOAD,   "load_hold");
      step(1'b1, 1'b1, 7'b0100011, E_NOP,    "rst_and_flush");
      step(1'b0, 1'b0, 7'b0100011, E_STORE,  "store_after_release");
      step(1'b1, 1'b0, 7'b1101111, E_NOP,    "rst_over_jal");
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      wait (stim_done);
      while (exp_q.size() > 0 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $finish;
   end

endmodule
